// File: rtl/mc_control.sv
// Multi-cycle control unit for a small RV32I subset: fetch/decode/execute/memory/writeback
// sequencing, immediate generation and program-counter update.
module mc_control #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    input  logic        alu_zero,
    input  logic        dmem_ready,
    output logic        instr_req,
    output logic [31:0] pc,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic [2:0]  alu_ctrl,
    output logic        alu_src_imm,
    output logic        mem_re,
    output logic        mem_we,
    output logic        reg_we,
    output logic        wb_sel_mem,
    output logic        illegal,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_XOR, OP_SLL, OP_ADDI, OP_LW, OP_SW, OP_BNE, OP_BAD
    } op_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    state_t      state_q, state_d;
    logic [31:0] ir;
    logic [31:0] pc_d;
    logic        started;
    op_t         op;
    logic [2:0]  alu_sel;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];
    assign rd     = ir[11:7];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign state  = state_q;

    always_comb begin
        op = OP_BAD;
        case (opcode)
            OPC_R: begin
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  op = OP_ADD;
                        3'b100:  op = OP_XOR;
                        3'b001:  op = OP_SLL;
                        default: op = OP_BAD;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    op = OP_SUB;
                end
            end
            OPC_I:      if (funct3 == 3'b000) op = OP_ADDI;
            OPC_LOAD:   if (funct3 == 3'b010) op = OP_LW;
            OPC_STORE:  if (funct3 == 3'b010) op = OP_SW;
            OPC_BRANCH: if (funct3 == 3'b001) op = OP_BNE;
            default:    op = OP_BAD;
        endcase
    end

    always_comb begin
        imm = 32'h0;
        case (opcode)
            OPC_I, OPC_LOAD: imm = {{20{ir[31]}}, ir[31:20]};
            OPC_STORE:       imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            OPC_BRANCH:      imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            default:         imm = 32'h0;
        endcase
    end

    always_comb begin
        alu_sel = 3'd0;
        case (op)
            OP_SUB:  alu_sel = 3'd1;
            OP_XOR:  alu_sel = 3'd2;
            OP_SLL:  alu_sel = 3'd3;
            OP_BNE:  alu_sel = 3'd4;
            default: alu_sel = 3'd0;
        endcase
    end

    // IR is stable from DECODE to the return to FETCH, so the ALU controls
    // derived from it naturally hold through MEM and WB.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc;
        instr_req   = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        reg_we      = 1'b0;
        wb_sel_mem  = 1'b0;
        alu_ctrl    = 3'd0;
        alu_src_imm = 1'b0;
        case (state_q)
            S_FETCH: begin
                instr_req = started;
                if (started && instr_valid) state_d = S_DECODE;
            end
            S_DECODE: state_d = (op == OP_BAD) ? S_TRAP : S_EXEC;
            S_EXEC, S_MEM, S_WB: begin
                alu_ctrl    = alu_sel;
                alu_src_imm = (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
                if (state_q == S_EXEC) begin
                    if (op == OP_LW || op == OP_SW) begin
                        state_d = S_MEM;
                    end else if (op == OP_BNE) begin
                        state_d = S_FETCH;
                        pc_d    = alu_zero ? pc + 32'd4 : pc + imm;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (state_q == S_MEM) begin
                    mem_re = (op == OP_LW);
                    mem_we = (op == OP_SW);
                    if (dmem_ready) begin
                        if (op == OP_LW) begin
                            state_d = S_WB;
                        end else begin
                            state_d = S_FETCH;
                            pc_d    = pc + 32'd4;
                        end
                    end
                end else begin
                    reg_we     = 1'b1;
                    wb_sel_mem = (op == OP_LW);
                    pc_d       = pc + 32'd4;
                    state_d    = S_FETCH;
                end
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    assign illegal = (state_q == S_TRAP);

    // started keeps instr_req low while reset is held and for the release cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc      <= RESET_PC;
            ir      <= 32'h0;
            started <= 1'b0;
        end else begin
            state_q <= state_d;
            pc      <= pc_d;
            started <= 1'b1;
            if (state_q == S_FETCH && started && instr_valid) ir <= instr;
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed and random instructions driven cycle by cycle,
// with expected fields and PC taken from the encoded instruction parameters.
module tb_mc_control;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int OP_ADD = 0, OP_SUB = 1, OP_XOR = 2, OP_SLL = 3;
    localparam int OP_ADDI = 4, OP_LW = 5, OP_SW = 6, OP_BNE = 7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        alu_zero;
    logic        dmem_ready;
    logic        instr_req;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [2:0]  alu_ctrl;
    logic        alu_src_imm;
    logic        mem_re, mem_we, reg_we, wb_sel_mem, illegal;
    logic [2:0]  state;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_pc;

    mc_control #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .alu_zero(alu_zero), .dmem_ready(dmem_ready), .instr_req(instr_req), .pc(pc),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .alu_ctrl(alu_ctrl),
        .alu_src_imm(alu_src_imm), .mem_re(mem_re), .mem_we(mem_we), .reg_we(reg_we),
        .wb_sel_mem(wb_sel_mem), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] encode(input int op, input logic [4:0] a_rd,
                                           input logic [4:0] a_rs1, input logic [4:0] a_rs2,
                                           input logic [31:0] iv);
        case (op)
            OP_ADD:  return {7'b0000000, a_rs2, a_rs1, 3'b000, a_rd, 7'b0110011};
            OP_SUB:  return {7'b0100000, a_rs2, a_rs1, 3'b000, a_rd, 7'b0110011};
            OP_XOR:  return {7'b0000000, a_rs2, a_rs1, 3'b100, a_rd, 7'b0110011};
            OP_SLL:  return {7'b0000000, a_rs2, a_rs1, 3'b001, a_rd, 7'b0110011};
            OP_ADDI: return {iv[11:0], a_rs1, 3'b000, a_rd, 7'b0010011};
            OP_LW:   return {iv[11:0], a_rs1, 3'b010, a_rd, 7'b0000011};
            OP_SW:   return {iv[11:5], a_rs2, a_rs1, 3'b010, iv[4:0], 7'b0100011};
            default: return {iv[12], iv[10:5], a_rs2, a_rs1, 3'b001, iv[4:1], iv[11], 7'b1100011};
        endcase
    endfunction

    function automatic logic [2:0] exp_alu(input int op);
        case (op)
            OP_SUB:  return 3'd1;
            OP_XOR:  return 3'd2;
            OP_SLL:  return 3'd3;
            OP_BNE:  return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; instr_valid = 1'b0; dmem_ready = 1'b0; alu_zero = 1'b0; instr = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_instr_req", 32'(instr_req), 32'd0);
        chk("rst_pc", pc, RESET_PC);
        chk("rst_reg_we", 32'(reg_we), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("post_rst_instr_req", 32'(instr_req), 32'd1);
        chk("post_rst_pc", pc, RESET_PC);
        model_pc = RESET_PC;
        exp_q.delete();
    endtask

    // One instruction from its FETCH cycle back to the next FETCH cycle.
    task automatic run_instr(input int op, input logic [4:0] a_rd, input logic [4:0] a_rs1,
                             input logic [4:0] a_rs2, input logic [31:0] iv,
                             input logic zero, input int dly);
        bit is_r, is_mem, has_wb;
        is_r   = (op <= OP_SLL);
        is_mem = (op == OP_LW) || (op == OP_SW);
        has_wb = is_r || (op == OP_ADDI) || (op == OP_LW);
        chk("fetch_req", 32'(instr_req), 32'd1);
        chk("fetch_pc", pc, model_pc);
        instr = encode(op, a_rd, a_rs1, a_rs2, iv);
        instr_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        instr_valid = 1'($urandom_range(0, 1)); instr = $urandom; dmem_ready = 1'($urandom_range(0, 1));
        chk("dec_rs1", 32'(rs1), 32'(a_rs1));
        if (op != OP_ADDI && op != OP_LW) chk("dec_rs2", 32'(rs2), 32'(a_rs2));
        if (op != OP_SW && op != OP_BNE) chk("dec_rd", 32'(rd), 32'(a_rd));
        if (!is_r) chk("dec_imm", imm, iv);
        chk("dec_instr_req", 32'(instr_req), 32'd0);
        @(posedge clk); @(negedge clk);
        alu_zero = zero;
        chk("exec_alu_ctrl", 32'(alu_ctrl), 32'(exp_alu(op)));
        chk("exec_src_imm", 32'(alu_src_imm), 32'((op == OP_ADDI) || is_mem));
        chk("exec_reg_we", 32'(reg_we), 32'd0);
        if (op == OP_BNE && !zero) exp_q.push_back(model_pc + iv);
        else exp_q.push_back(model_pc + 32'd4);
        if (is_mem) begin
            for (int i = 0; i <= dly; i++) begin
                @(posedge clk); @(negedge clk);
                instr_valid = 1'b0;
                dmem_ready = (i == dly);
                chk("mem_re", 32'(mem_re), 32'(op == OP_LW));
                chk("mem_we", 32'(mem_we), 32'(op == OP_SW));
                chk("mem_alu_hold", 32'(alu_ctrl), 32'd0);
            end
        end
        @(posedge clk); @(negedge clk);
        instr_valid = 1'b0; dmem_ready = 1'b0; alu_zero = 1'b0;
        if (has_wb) begin
            chk("wb_reg_we", 32'(reg_we), 32'd1);
            chk("wb_sel_mem", 32'(wb_sel_mem), 32'(op == OP_LW));
            chk("wb_alu_hold", 32'(alu_ctrl), 32'(exp_alu(op)));
            chk("wb_src_hold", 32'(alu_src_imm), 32'((op == OP_ADDI) || is_mem));
            chk("wb_mem_re", 32'(mem_re), 32'd0);
            @(posedge clk); @(negedge clk);
        end
        model_pc = exp_q.pop_front();
        chk("next_reg_we", 32'(reg_we), 32'd0);
        chk("next_pc", pc, model_pc);
    endtask

    initial begin
        int          op;
        logic [11:0] r12;
        do_reset();

        run_instr(OP_ADD, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 0);
        run_instr(OP_BNE, 5'd0, 5'd4, 5'd5, 32'hFFFF_FFF8, 1'b0, 0);
        run_instr(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 0);
        run_instr(OP_SUB, 5'd5, 5'd6, 5'd7, 32'h0, 1'b0, 0);
        run_instr(OP_XOR, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 0);
        run_instr(OP_SLL, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 0);
        run_instr(OP_ADDI, 5'd9, 5'd9, 5'd0, 32'hFFFF_F800, 1'b0, 0);
        run_instr(OP_BNE, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 1'b0, 0);
        run_instr(OP_ADDI, 5'd2, 5'd2, 5'd0, 32'd1, 1'b0, 0);
        run_instr(OP_ADDI, 5'd2, 5'd2, 5'd0, 32'd1, 1'b0, 0);
        run_instr(OP_BNE, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 1'b1, 0);
        run_instr(OP_LW, 5'd1, 5'd2, 5'd0, 32'd8, 1'b0, 3);
        run_instr(OP_SW, 5'd0, 5'd2, 5'd3, 32'hFFFF_FFFC, 1'b0, 2);

        for (int k = 0; k < 24; k++) begin
            op  = int'($urandom_range(0, 7));
            r12 = 12'($urandom);
            run_instr(op, 5'($urandom), 5'($urandom), 5'($urandom),
                      (op == OP_BNE) ? {{19{r12[11]}}, r12, 1'b0} : {{20{r12[11]}}, r12},
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        chk("trap_fetch_req", 32'(instr_req), 32'd1);
        instr = 32'hFFFF_FFFF; instr_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        instr_valid = 1'b0;
        chk("trap_dec_illegal", 32'(illegal), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            instr_valid = 1'b1; dmem_ready = 1'b1;
            chk("trap_illegal", 32'(illegal), 32'd1);
            chk("trap_instr_req", 32'(instr_req), 32'd0);
            chk("trap_reg_we", 32'(reg_we), 32'd0);
            chk("trap_pc_frozen", pc, model_pc);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("trap_rst_illegal", 32'(illegal), 32'd0);
        chk("trap_rst_pc", pc, RESET_PC);
        do_reset();

        run_instr(OP_ADD, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 0);
        instr = encode(OP_SW, 5'd0, 5'd2, 5'd5, 32'd12); instr_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        instr_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        dmem_ready = 1'b0;
        chk("abort_mem_we_before", 32'(mem_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_mem_we", 32'(mem_we), 32'd0);
        chk("abort_reg_we", 32'(reg_we), 32'd0);
        chk("abort_pc", pc, RESET_PC);
        chk("abort_instr_req", 32'(instr_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        model_pc = RESET_PC;
        exp_q.delete();
        run_instr(OP_LW, 5'd7, 5'd8, 5'd0, 32'd16, 1'b0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
